// File: rtl/uart_par_calc_pkg.sv
// Shared UART constants: parity-type encodings and the default data width
// used across the transmitter datapath.
package uart_par_calc_pkg;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int unsigned DATA_WIDTH = 8;

endpackage

// File: rtl/uart_par_calc.sv
// UART transmit parity generator: captures even/odd parity of P_DATA on
// DATA_valid and holds it on par_bit for the serializer.
module uart_par_calc
    import uart_par_calc_pkg::*;
#(
    parameter int unsigned IN_width = DATA_WIDTH
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [IN_width-1:0] P_DATA,
    input  logic                DATA_valid,
    input  logic                PAR_TYP,
    output logic                par_bit
);

    // Odd parity is the inverse of the plain XOR-reduction.
    logic par_next_c;

    always_comb begin
        par_next_c = (^P_DATA) ^ (PAR_TYP == PAR_ODD);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            par_bit <= 1'b0;
        end else if (DATA_valid) begin
            par_bit <= par_next_c;
        end
    end

endmodule

// File: tb/tb_uart_par_calc.sv
// Directed bench for uart_par_calc: reset, even/odd parity, hold, streaming
// capture and mid-operation reset.
module tb_uart_par_calc;

    localparam int unsigned W = 8;

    logic         CLK;
    logic         RST;
    logic [W-1:0] P_DATA;
    logic         DATA_valid;
    logic         PAR_TYP;
    logic         par_bit;

    int checks   = 0;
    int failures = 0;

    uart_par_calc #(.IN_width(W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_valid (DATA_valid),
        .PAR_TYP    (PAR_TYP),
        .par_bit    (par_bit)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%b expected=%b", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One-cycle DATA_valid pulse, then check the captured parity.
    task automatic pulse(input string tag, input logic [W-1:0] d,
                         input logic typ, input logic exp);
        P_DATA     = d;
        PAR_TYP    = typ;
        DATA_valid = 1'b1;
        step();
        DATA_valid = 1'b0;
        check(tag, par_bit, exp);
    endtask

    initial begin
        RST        = 1'b1;
        DATA_valid = 1'b1;
        P_DATA     = 8'hFF;
        PAR_TYP    = 1'b1;

        // Reset dominates DATA_valid for two edges.
        step();
        check("reset_c1", par_bit, 1'b0);
        step();
        check("reset_c2", par_bit, 1'b0);
        RST = 1'b0;
        step();
        check("post_reset_ff_odd", par_bit, 1'b1);
        DATA_valid = 1'b0;

        pulse("even_even_weight", 8'b11001100, 1'b0, 1'b0);
        pulse("even_odd_weight",  8'b01001100, 1'b0, 1'b1);
        pulse("odd_even_weight",  8'b11001100, 1'b1, 1'b1);
        pulse("odd_odd_weight",   8'b10001100, 1'b1, 1'b0);

        // Hold: inputs wiggle with DATA_valid low, par_bit must not move.
        pulse("hold_setup", 8'b01001100, 1'b0, 1'b1);
        P_DATA = 8'h00;
        for (int i = 0; i < 5; i++) begin
            PAR_TYP = ~PAR_TYP;
            step();
            check($sformatf("hold_c%0d", i), par_bit, 1'b1);
        end

        // Boundary words.
        pulse("zero_even", 8'h00, 1'b0, 1'b0);
        pulse("zero_odd",  8'h00, 1'b1, 1'b1);
        pulse("ones_even", 8'hFF, 1'b0, 1'b0);
        pulse("ones_odd",  8'hFF, 1'b1, 1'b1);

        // Streaming capture: recomputed every cycle from current inputs.
        DATA_valid = 1'b1;
        P_DATA = 8'h01; PAR_TYP = 1'b0; step();
        check("stream_c0", par_bit, 1'b1);
        P_DATA = 8'h03; PAR_TYP = 1'b0; step();
        check("stream_c1", par_bit, 1'b0);
        P_DATA = 8'h07; PAR_TYP = 1'b1; step();
        check("stream_c2", par_bit, 1'b0);
        P_DATA = 8'h80; PAR_TYP = 1'b1; step();
        check("stream_c3", par_bit, 1'b0);
        DATA_valid = 1'b0;

        // Mid-operation reset discards the held parity.
        pulse("midrst_setup", 8'b01001100, 1'b0, 1'b1);
        RST = 1'b1;
        step();
        check("midrst_edge", par_bit, 1'b0);
        RST = 1'b0;
        P_DATA = 8'h01;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("midrst_hold_c%0d", i), par_bit, 1'b0);
        end
        pulse("midrst_recapture", 8'h01, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_par_calc.md
Name: uart_par_calc

Overview:
- Parity generator for the UART transmitter datapath.
- Samples the parallel data word when DATA_valid is asserted and computes even or odd parity over it, as selected by PAR_TYP.
- Holds the result on par_bit until the next valid word, so the serializer can insert it as the parity bit after the data bits.

Parameters:
- IN_width, default 8: width of the parallel data word P_DATA; legal range 1..32.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- P_DATA  input  IN_width  parallel data word to be transmitted.
- DATA_valid  input  1  qualifies P_DATA; single- or multi-cycle pulse.
- PAR_TYP  input  1  parity type: 0 = even, 1 = odd.
- par_bit  output  1  registered parity bit for the last accepted word.

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (RST); it is sampled only on the rising CLK edge.
- Reset: when RST = 1 at a rising edge, par_bit <= 0, and any internal capture register <= 0. Reset has priority over DATA_valid.
- Capture: when RST = 0 and DATA_valid = 1 at a rising edge, par_bit is updated.
  - Even parity (PAR_TYP = 0): par_bit <= XOR-reduction of all IN_width bits of P_DATA. The total count of ones in data plus parity bit is even.
  - Odd parity (PAR_TYP = 1): par_bit <= inverted XOR-reduction. The total count of ones is odd.
- Hold: when RST = 0 and DATA_valid = 0, par_bit keeps its value regardless of changes on P_DATA or PAR_TYP.
- Latency: par_bit reflects the new word one cycle after the edge that samples DATA_valid = 1. P_DATA and PAR_TYP are sampled on that same edge.
- DATA_valid held high for N cycles: par_bit is recomputed every cycle from the current P_DATA and PAR_TYP; the last sampled values win.
- PAR_TYP change without DATA_valid: no effect until the next capture.
- Reset asserted mid-operation: par_bit returns to 0 on that edge; the previously computed parity is discarded.
- No combinational path from inputs to par_bit; the output is driven directly from a flop.
- All-zero data: even parity gives 0, odd parity gives 1. All-ones data with IN_width even: even gives 0, odd gives 1.

Decomposition:
- Shared UART package holds:
  - parity-type constants PAR_EVEN = 1'b0 and PAR_ODD = 1'b1;
  - the default data width constant (8), reused by the serializer and FSM.
- No sub-module: a single always block for the register plus a reduction XOR is sufficient.
- Parity is computed in-line; a separate xor-tree module is not warranted.

Test Plan:
- Reset: hold RST = 1 for 2 cycles with DATA_valid = 1 and P_DATA = 8'hFF, PAR_TYP = 1 -> par_bit = 0 throughout reset; first edge after release updates par_bit to 1.
- Even parity, even weight: P_DATA = 8'b11001100, PAR_TYP = 0, one-cycle DATA_valid -> par_bit = 0 one cycle later.
- Even parity, odd weight: P_DATA = 8'b01001100, PAR_TYP = 0, pulse DATA_valid -> par_bit = 1.
- Odd parity: P_DATA = 8'b11001100, PAR_TYP = 1, pulse -> par_bit = 1. Then P_DATA = 8'b10001100, PAR_TYP = 1, pulse -> par_bit = 0.
- Hold: after a capture giving par_bit = 1, change P_DATA to 8'h00 and toggle PAR_TYP for 5 cycles with DATA_valid = 0 -> par_bit stays 1.
- Mid-operation reset: capture 8'b01001100 even (par_bit = 1), then assert RST for 1 cycle -> par_bit = 0 at that edge; it stays 0 until the next DATA_valid.
